// File: rtl/bitonic_pkg.sv
// Shared definitions for the bitonic sorter: key width, lane count, pad key.
package bitonic_pkg;

  localparam int unsigned KEY_WIDTH     = 32;
  localparam int unsigned DEFAULT_LANES = 8;

  // Maximum key; padded lanes sort to the end of an ascending sort.
  localparam logic [KEY_WIDTH-1:0] PAD_KEY = '1;

  typedef logic [KEY_WIDTH-1:0] key_t;
  typedef logic [$clog2(DEFAULT_LANES)-1:0] lane_idx_t;

  // Bits needed to address one lane of a frame (at least 1).
  function automatic int unsigned lane_idx_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/frame_bank.sv
// One frame buffer: LANES key registers plus a count and a valid flag.
module frame_bank
  import bitonic_pkg::*;
#(
  parameter int unsigned WIDTH = KEY_WIDTH,
  parameter int unsigned LANES = DEFAULT_LANES,
  parameter logic [WIDTH-1:0] PAD_VALUE = {WIDTH{1'b1}},
  localparam int unsigned IDX_W = lane_idx_width(LANES),
  localparam int unsigned CNT_W = $clog2(LANES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   close,
  input  logic [CNT_W-1:0]       close_count,
  input  logic                   clear,
  output logic [LANES*WIDTH-1:0] frame,
  output logic [CNT_W-1:0]       count,
  output logic                   valid
);

  // Lane storage: reset/clear refill with pad, otherwise write the addressed lane.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      frame <= {LANES{PAD_VALUE}};
    end else if (wr_en) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (wr_idx == IDX_W'(k)) frame[k*WIDTH +: WIDTH] <= wr_data;
      end
    end
  end

  // Frame status: close publishes the frame, clear releases the bank.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      valid <= 1'b0;
    end else if (close) begin
      count <= close_count;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/bitonic_frame_loader.sv
// Packs a serial key stream into padded LANES-wide frames, ping-pong buffered.
module bitonic_frame_loader
  import bitonic_pkg::*;
#(
  parameter int unsigned WIDTH = KEY_WIDTH,
  parameter int unsigned LANES = DEFAULT_LANES,
  parameter logic [WIDTH-1:0] PAD_VALUE = {WIDTH{1'b1}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [LANES*WIDTH-1:0]       out_frame,
  output logic [$clog2(LANES+1)-1:0]   out_count,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned IDX_W = lane_idx_width(LANES);
  localparam int unsigned CNT_W = $clog2(LANES + 1);

  logic [IDX_W-1:0]       idx;
  logic                   wr_bank;
  logic                   rd_bank;
  logic [1:0]             bank_valid;
  logic [LANES*WIDTH-1:0] bank_frame [2];
  logic [CNT_W-1:0]       bank_count [2];
  logic                   accept;
  logic                   close;
  logic                   drain;
  logic [CNT_W-1:0]       close_count;

  // Handshake decode; every output is a mux of bank registers only.
  assign in_ready    = !bank_valid[wr_bank];
  assign out_valid   = bank_valid[rd_bank];
  assign out_frame   = bank_frame[rd_bank];
  assign out_count   = bank_count[rd_bank];
  assign accept      = in_valid && in_ready;
  assign close       = accept && ((idx == IDX_W'(LANES - 1)) || in_last);
  assign drain       = out_valid && out_ready;
  assign close_count = CNT_W'(idx) + CNT_W'(1);

  // Two banks; fill and drain always address different banks when both act.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank #(
      .WIDTH     (WIDTH),
      .LANES     (LANES),
      .PAD_VALUE (PAD_VALUE)
    ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (accept && (wr_bank == 1'(b))),
      .wr_idx      (idx),
      .wr_data     (in_data),
      .close       (close && (wr_bank == 1'(b))),
      .close_count (close_count),
      .clear       (drain && (rd_bank == 1'(b))),
      .frame       (bank_frame[b]),
      .count       (bank_count[b]),
      .valid       (bank_valid[b])
    );
  end

  // Lane index and bank pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
    end else begin
      if (accept) idx <= close ? '0 : idx + IDX_W'(1);
      if (close)  wr_bank <= !wr_bank;
      if (drain)  rd_bank <= !rd_bank;
    end
  end

endmodule

// File: tb/tb_bitonic_frame_loader.sv
// Self-checking bench: frame-level FIFO model plus directed literal checks.
module tb_bitonic_frame_loader;

  localparam int unsigned W  = 32;
  localparam int unsigned L  = 8;
  localparam int unsigned CW = $clog2(L + 1);
  localparam int unsigned FW = L * W;
  localparam logic [W-1:0] PAD = '1;

  logic          clk;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [FW-1:0] out_frame;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready;

  bitonic_frame_loader #(.WIDTH(W), .LANES(L), .PAD_VALUE(PAD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_frame (out_frame),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: closed frames wait in a FIFO of depth two; cur holds the open frame.
  logic [FW-1:0] fq_frame [$];
  int            fq_cnt   [$];
  logic [W-1:0]  cur      [$];
  bit            started = 0;
  bit            rand_ready = 0;

  // DUT-observed handshakes.
  bit            hs_pend = 0;
  int            cnt_pend = 0;
  int            dut_frames = 0;
  int            dut_keys = 0;
  int            words_sent = 0;

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_ready();
    return fq_frame.size() < 2;
  endfunction

  task automatic update_model();
    bit rdy;
    bit drn;
    logic [FW-1:0] f;
    if (rst) begin
      fq_frame.delete();
      fq_cnt.delete();
      cur.delete();
      started = 1;
      return;
    end
    rdy = model_ready();
    drn = (fq_frame.size() > 0) && out_ready;
    if (in_valid && rdy) begin
      cur.push_back(in_data);
      words_sent++;
      if (cur.size() == L || in_last) begin
        f = {L{PAD}};
        for (int k = 0; k < cur.size(); k++) f[k*W +: W] = cur[k];
        fq_frame.push_back(f);
        fq_cnt.push_back(cur.size());
        cur.delete();
      end
    end
    if (drn) begin
      void'(fq_frame.pop_front());
      void'(fq_cnt.pop_front());
    end
  endtask

  task automatic compare_model();
    if (!started) return;
    check("in_ready", FW'(in_ready), FW'(model_ready()));
    check("out_valid", FW'(out_valid), FW'(fq_frame.size() > 0));
    if (fq_frame.size() > 0) begin
      check("out_count", FW'(out_count), FW'(fq_cnt[0]));
      check("out_frame", out_frame, fq_frame[0]);
    end
    hs_pend  = out_valid;
    cnt_pend = int'(out_count);
  endtask

  // One clock: model steps on the edge, DUT compared on the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (hs_pend && out_ready && !rst) begin
      dut_frames++;
      dut_keys += cnt_pend;
    end
    update_model();
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_last  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = $urandom;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  task automatic send(input logic [W-1:0] d, input bit last);
    bit ok;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 200; t++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      ok = model_ready();
      tick();
      if (ok) return;
    end
    check("send_timeout", FW'(1'b0), FW'(1'b1));
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("reset_out_valid", FW'(out_valid), FW'(1'b0));
    check("reset_out_count", FW'(out_count), FW'(0));
    check("reset_out_frame", out_frame, {FW{1'b1}});
    check("reset_in_ready", FW'(in_ready), FW'(1'b1));

    // Full 8-word frame, descending keys.
    for (int i = 8; i >= 1; i--) send(W'(i), 1'b0);
    check("t1_valid", FW'(out_valid), FW'(1'b1));
    check("t1_count", FW'(out_count), FW'(8));
    check("t1_frame", out_frame,
          256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
    idle(1, 1'b0);
    check("t1_one_cycle", FW'(out_valid), FW'(1'b0));

    // Short frame closed by in_last, then a one-word frame.
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b1);
    check("t2_count", FW'(out_count), FW'(3));
    check("t2_frame", out_frame,
          256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_0000000C_0000000B_0000000A);
    send(32'hD, 1'b1);
    check("t2_next_count", FW'(out_count), FW'(1));
    check("t2_next_lane0", FW'(out_frame[W-1:0]), FW'(32'hD));
    idle(2, 1'b0);

    // Back-pressure: two frames held, then released in order.
    out_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(W'(32'h300 + i), 1'b0);
    check("t3_stall", FW'(in_ready), FW'(1'b0));
    idle(2, 1'b0);
    check("t3_held_frame", out_frame,
          256'h00000308_00000307_00000306_00000305_00000304_00000303_00000302_00000301);
    out_ready = 1'b1;
    idle(1, 1'b0);
    check("t3_ready_back", FW'(in_ready), FW'(1'b1));
    check("t3_second_lane0", FW'(out_frame[W-1:0]), FW'(32'h309));
    for (int i = 17; i <= 24; i++) send(W'(32'h300 + i), 1'b0);
    idle(4, 1'b0);

    // in_last without in_valid is ignored.
    for (int i = 1; i <= 3; i++) send(W'(32'h400 + i), 1'b0);
    in_valid = 1'b0; in_last = 1'b1;
    tick();
    for (int i = 4; i <= 7; i++) send(W'(32'h400 + i), 1'b0);
    check("t4_not_closed", FW'(out_valid), FW'(1'b0));
    send(32'h408, 1'b0);
    check("t4_count", FW'(out_count), FW'(8));
    idle(3, 1'b0);

    // Reset with one held and one partial frame.
    out_ready = 1'b0;
    for (int i = 1; i <= 13; i++) send(W'(32'h500 + i), 1'b0);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    check("t5_valid", FW'(out_valid), FW'(1'b0));
    check("t5_frame", out_frame, {FW{1'b1}});
    check("t5_count", FW'(out_count), FW'(0));
    rst = 1'b0; out_ready = 1'b1;
    dut_frames = 0; dut_keys = 0;
    tick();
    check("t5_in_ready", FW'(in_ready), FW'(1'b1));
    for (int i = 1; i <= 8; i++) send(W'(32'h600 + i), 1'b0);
    idle(3, 1'b0);
    check("t5_frames", FW'(dut_frames), FW'(1));
    check("t5_keys", FW'(dut_keys), FW'(8));

    // Randomised traffic.
    rand_ready = 1;
    dut_keys = 0; words_sent = 0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 1'b1);
      send($urandom, $urandom_range(0, 5) == 0);
    end
    in_valid = 1'b0;
    send(32'h7FF, 1'b1);
    rand_ready = 0; out_ready = 1'b1;
    idle(6, 1'b0);
    check("t6_words_sent", FW'(words_sent), FW'(1001));
    check("t6_keys_out", FW'(dut_keys), FW'(1001));
    check("t6_drained", FW'(out_valid), FW'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
